uart_rx: RTL and testbench

Serial receiver for the UART link: consumes the S_Data line produced by the transmitter and rebuilds each frame into a parallel byte. The frame is a start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit, and a stop bit (1). Parity rules match the transmitter. The bit clock is recovered by oversampling RX_IN PRESCALE times per bit on the system clock, and the block reports parity and framing errors per frame.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sampler.sv | 74 +++++++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver files.
//   rx_state_e  - receiver FSM states
//   EVEN / ODD  - values of the Parity_Type input
//   majority3   - 2-of-3 vote used by the majority sampler
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit tick counter and bit sampling for uart_rx.
// Build option: UART_RX_MAJORITY_EN selects a 3-sample majority vote around mid-bit;
// otherwise a single sample is taken at tick PRESCALE/2.
// Ports:
//   clk, rst     - system clock, async active-high reset
//   run          - receiver is inside a frame (FSM not in IDLE)
//   start        - start bit detected in IDLE this cycle
//   rx_s         - synchronized serial line
//   bit_val      - sampled bit value, valid while sample_done is high
//   sample_done  - strobe: bit decision made this cycle
//   bit_end      - strobe: last tick of the current bit
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic start,
  input  logic rx_s,
  output logic bit_val,
  output logic sample_done,
  output logic bit_end
);

  localparam int unsigned TW = $clog2(PRESCALE);
  localparam logic [TW-1:0] TICK_MID  = TW'(PRESCALE / 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(PRESCALE - 1);

  logic [TW-1:0] tick;

  // The start-detect cycle counts as tick 0 of the start bit, so the next cycle is tick 1.
  // This keeps bit boundaries aligned to the line and back-to-back frames lose no cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= '0;
    end else if (start) begin
      tick <= TW'(1);
    end else if (run) begin
      tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
    end else begin
      tick <= '0;
    end
  end

  assign bit_end = run && (tick == TICK_LAST);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] TICK_PRE  = TICK_MID - 1'b1;
  localparam logic [TW-1:0] TICK_POST = TICK_MID + 1'b1;

  logic samp_a;
  logic samp_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_a <= 1'b0;
      samp_b <= 1'b0;
    end else if (run) begin
      if (tick == TICK_PRE) samp_a <= rx_s;
      if (tick == TICK_MID) samp_b <= rx_s;
    end
  end

  // Third vote is the live sample at PRESCALE/2+1.
  assign sample_done = run && (tick == TICK_POST);
  assign bit_val     = majority3(samp_a, samp_b, rx_s);
`else
  assign sample_done = run && (tick == TICK_MID);
  assign bit_val     = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver. Frame = start(0), DATA_WIDTH data bits LSB first,
// optional parity bit, stop(1). Reports one result pulse per frame, one cycle after the
// final stop tick.
// Build option: UART_RX_MAJORITY_EN (see uart_rx_sampler) enables majority-vote sampling.
// Ports:
//   CLK, RST       - system clock, async active-high reset
//   RX_IN          - serial line, idles high, asynchronous to CLK
//   Parity_Enable  - frame carries a parity bit (latched at start bit)
//   Parity_Type    - 0 even, 1 odd (latched at start bit)
//   P_DATA         - last received data byte
//   Data_Valid     - pulse for an error-free frame
//   Parity_Error   - pulse on parity mismatch
//   Stop_Error     - pulse when the stop bit was sampled 0
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE   = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  Parity_Enable,
  input  logic                  Parity_Type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic                  rx_meta;
  logic                  rx_s;
  rx_state_e             state;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_en;
  logic                  par_type;
  logic                  par_err;
  logic                  stop_bit;
  logic                  armed;

  logic                  run;
  logic                  start_det;
  logic                  bit_val;
  logic                  sample_done;
  logic                  bit_end;
  logic [DATA_WIDTH-1:0] shift_nx;
  logic                  par_err_nx;
  logic                  stop_nx;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  assign run       = (state != IDLE);
  // armed blocks a held-low (break) line from retriggering a frame.
  assign start_det = (state == IDLE) && !rx_s && armed;

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .clk        (CLK),
    .rst        (RST),
    .run        (run),
    .start      (start_det),
    .rx_s       (rx_s),
    .bit_val    (bit_val),
    .sample_done(sample_done),
    .bit_end    (bit_end)
  );

  // Fold the current sample in combinationally so a decision landing on the last
  // tick (small PRESCALE with majority) is still seen at bit_end.
  always_comb begin
    shift_nx   = shift;
    par_err_nx = par_err;
    stop_nx    = stop_bit;
    if (sample_done) begin
      case (state)
        DATA:    shift_nx[bit_cnt] = bit_val;
        PARITY:  par_err_nx = bit_val != (^shift ^ (par_type == ODD));
        STOP:    stop_nx = bit_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      par_en       <= 1'b0;
      par_type     <= 1'b0;
      par_err      <= 1'b0;
      stop_bit     <= 1'b1;
      armed        <= 1'b0;
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      Data_Valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      shift        <= shift_nx;
      par_err      <= par_err_nx;
      stop_bit     <= stop_nx;
      if (rx_s) armed <= 1'b1;

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (start_det) begin
            state    <= START;
            armed    <= 1'b0;
            par_en   <= Parity_Enable;
            par_type <= Parity_Type;
            par_err  <= 1'b0;
            stop_bit <= 1'b1;
          end
        end
        START: begin
          if (sample_done && bit_val) begin
            state <= IDLE;
          end else if (bit_end) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= par_en ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_end) state <= STOP;
        end
        STOP: begin
          if (bit_end) begin
            state        <= IDLE;
            P_DATA       <= shift_nx;
            Stop_Error   <= ~stop_nx;
            Parity_Error <= par_err_nx;
            Data_Valid   <= stop_nx & ~par_err_nx;
            // A low stop bit may be a break: require the line to go high before rearming.
            if (!stop_nx) armed <= rx_s;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (PRESCALE = 8, DATA_WIDTH = 8).
// Line bits are driven on the falling clock edge; outputs are sampled on the falling edge.
module tb_uart_rx;

  localparam int unsigned PRESCALE   = 8;
  localparam int unsigned DATA_WIDTH = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int GLITCH_BIT = 3;
`else
  localparam int GLITCH_BIT = -1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       Parity_Enable = 1'b0;
  logic       Parity_Type = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Parity_Error;
  logic       Stop_Error;

  int         n_checks = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         dv_cyc[$];
  logic [7:0] dv_dat[$];
  int         pe_n = 0;
  int         se_n = 0;
  int         dv0, pe0, se0, t0;

  uart_rx #(
    .PRESCALE  (PRESCALE),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Parity_Enable(Parity_Enable),
    .Parity_Type  (Parity_Type),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Log every result cycle (counting high cycles, so a stuck pulse shows as extra).
  always @(negedge CLK) begin
    if (Data_Valid) begin
      dv_cyc.push_back(cyc);
      dv_dat.push_back(P_DATA);
    end
    if (Parity_Error) pe_n++;
    if (Stop_Error) se_n++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    RX_IN = b;
    if (glitch) begin
      repeat (4) @(negedge CLK);
      RX_IN = ~b;
      @(negedge CLK);
      RX_IN = b;
      repeat (3) @(negedge CLK);
    end else begin
      repeat (PRESCALE) @(negedge CLK);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_on, input logic par_bit,
                            input logic stop_val, input int glitch_idx);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], i == glitch_idx);
    if (par_on) drive_bit(par_bit, 1'b0);
    drive_bit(stop_val, 1'b0);
    RX_IN = 1'b1;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic snap();
    dv0 = dv_cyc.size();
    pe0 = pe_n;
    se0 = se_n;
    t0  = cyc;
  endtask

  function automatic int last_lat();
    return (dv_cyc.size() > dv0) ? dv_cyc[dv0] - t0 : -1;
  endfunction

  initial begin
    logic [7:0] c3;
    c3 = 8'hC3;
    #1 RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_pdata", P_DATA, 0);
    check("rst_dv", Data_Valid, 0);
    check("rst_pe", Parity_Error, 0);
    check("rst_se", Stop_Error, 0);
    RST = 1'b0;
    idle(10);

    // No parity, 0xA5: result 2 sync + 80 frame cycles after the start bit is driven.
    snap();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
    idle(16);
    check("a5_dv_cnt", dv_cyc.size() - dv0, 1);
    check("a5_pdata", P_DATA, 8'hA5);
    check("a5_latency", last_lat(), 82);
    check("a5_pe", pe_n - pe0, 0);
    check("a5_se", se_n - se0, 0);

    // Even parity, 0x3C has four ones -> parity bit 0 is correct.
    Parity_Enable = 1'b1;
    Parity_Type   = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1);
    idle(16);
    check("3c_dv_cnt", dv_cyc.size() - dv0, 1);
    check("3c_pdata", P_DATA, 8'h3C);
    check("3c_pe", pe_n - pe0, 0);
    check("3c_latency", last_lat(), 90);

    snap();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1);
    idle(16);
    check("3c_bad_pe", pe_n - pe0, 1);
    check("3c_bad_dv", dv_cyc.size() - dv0, 0);
    check("3c_bad_se", se_n - se0, 0);

    // Stop bit low on 0x81: Stop_Error only, data still loaded.
    Parity_Enable = 1'b0;
    snap();
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, -1);
    idle(16);
    check("81_se", se_n - se0, 1);
    check("81_dv", dv_cyc.size() - dv0, 0);
    check("81_pe", pe_n - pe0, 0);
    check("81_pdata", P_DATA, 8'h81);

    // 3-cycle low glitch is rejected, then 0x0F is received.
    snap();
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    idle(30);
    check("glitch_dv", dv_cyc.size() - dv0, 0);
    check("glitch_err", (pe_n - pe0) + (se_n - se0), 0);
    snap();
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, -1);
    idle(16);
    check("0f_dv_cnt", dv_cyc.size() - dv0, 1);
    check("0f_pdata", P_DATA, 8'h0F);

    // Break: line held low well past a frame gives one Stop_Error and no restart.
    snap();
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1);
    RX_IN = 1'b0;
    repeat (60) @(negedge CLK);
    check("brk_se", se_n - se0, 1);
    check("brk_dv", dv_cyc.size() - dv0, 0);
    idle(30);
    check("brk_se_after", se_n - se0, 1);
    check("brk_dv_after", dv_cyc.size() - dv0, 0);

    // Odd parity, 0x55 and 0xAA back-to-back (both need parity bit 1).
    Parity_Enable = 1'b1;
    Parity_Type   = 1'b1;
    snap();
    send_frame(8'h55, 1'b1, 1'b1, 1'b1, GLITCH_BIT);
    send_frame(8'hAA, 1'b1, 1'b1, 1'b1, -1);
    idle(16);
    check("b2b_dv_cnt", dv_cyc.size() - dv0, 2);
    check("b2b_pe", pe_n - pe0, 0);
    check("b2b_latency", last_lat(), 90);
    if (dv_cyc.size() >= dv0 + 2) begin
      check("b2b_gap", dv_cyc[dv0+1] - dv_cyc[dv0], 88);
      check("b2b_d0", dv_dat[dv0], 8'h55);
      check("b2b_d1", dv_dat[dv0+1], 8'hAA);
    end

    // Reset during data bit 4 of 0xC3 clears outputs immediately.
    Parity_Enable = 1'b0;
    snap();
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(c3[i], 1'b0);
    RX_IN = c3[4];
    repeat (4) @(negedge CLK);
    check("pre_rst_pdata", P_DATA, 8'hAA);
    RST = 1'b1;
    #1;
    check("mid_rst_pdata", P_DATA, 0);
    check("mid_rst_flags", {Data_Valid, Parity_Error, Stop_Error}, 0);
    @(negedge CLK);
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    idle(20);
    check("post_rst_dv", dv_cyc.size() - dv0, 0);
    snap();
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1);
    idle(16);
    check("c3_dv_cnt", dv_cyc.size() - dv0, 1);
    check("c3_pdata", P_DATA, 8'hC3);
    check("c3_latency", last_lat(), 82);
    check("c3_err", (pe_n - pe0) + (se_n - se0), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
